// File: rtl/s_pg_serial_sub_pkg.sv
// Shared types and defaults for the bit-serial signed subtractor.
package s_pg_serial_sub_pkg;

  localparam int N_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pg_sub_cell.sv
// One propagate/generate full-adder slice; the serial subtractor reuses it every cycle.
module pg_sub_cell (
  input  logic a_i,
  input  logic nb_i,
  input  logic cin,
  output logic p,
  output logic g,
  output logic s,
  output logic cout
);

  assign p    = a_i ^ nb_i;
  assign g    = a_i & nb_i;
  assign s    = p ^ cin;
  assign cout = g | (p & cin);

endmodule

// File: rtl/s_pg_serial_sub.sv
// Bit-serial signed subtractor: out = a - b as a + ~b + 1, one bit per cycle, LSB first.
module s_pg_serial_sub
  import s_pg_serial_sub_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out,
  output logic         busy
);

  localparam int CW = $clog2(N);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sh, nb_sh;
  logic [N-1:0]   res_lo;
  logic           res_msb;
  logic           carry;
  logic           last;
  logic           p, g, s, cout;

  assign last = (cnt == CW'(N - 1));

  pg_sub_cell u_cell (
    .a_i  (a_sh[0]),
    .nb_i (nb_sh[0]),
    .cin  (carry),
    .p    (p),
    .g    (g),
    .s    (s),
    .cout (cout)
  );

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      nb_sh   <= '0;
      carry   <= 1'b0;
      res_lo  <= '0;
      res_msb <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            nb_sh <= ~b;
            carry <= 1'b1;  // the +1 of the two's-complement negation of b
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          nb_sh  <= nb_sh >> 1;
          carry  <= cout;
          res_lo <= {s, res_lo[N-1:1]};
          if (last) begin
            // Sign-extended top bit: the (N+1)-bit result can never overflow.
            res_msb <= p ^ cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out = {res_msb, res_lo};

endmodule

// File: tb/tb_s_pg_serial_sub.sv
// Scoreboard bench for s_pg_serial_sub (N=16): directed corner cases plus randomized stalls.
module tb_s_pg_serial_sub;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   out;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic prev_ov = 1'b0;
  logic [N:0] sb[$];
  bit prod_done = 1'b0;

  s_pg_serial_sub #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: push expected on accepted operands, pop and compare on result handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back({a[N-1], a} - {b[N-1], b});
      accept_cyc = cyc + 1;
    end
    if (rst_n && out_valid && !prev_ov)
      check("latency", cyc - accept_cyc, N);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 1);
      else check("result", 32'(out), 32'(sb.pop_front()));
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv);
    int t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = av; b = bv;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", t, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_out"}, 32'(out), 0);
  endtask

  initial begin
    logic [N:0] held;
    int t;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    // Directed values, consumer always ready.
    out_ready = 1'b1;
    send(16'd5, 16'd3);
    drain();
    check("r5m3_direct", 32'(out), 32'h00002);
    send(16'h8000, 16'h7FFF);
    drain();
    check("min_minus_max", 32'(out), 32'h10001);
    send(16'h7FFF, 16'h8000);
    drain();
    check("max_minus_min", 32'(out), 32'h0FFFF);
    send(16'h0000, 16'h0000);
    drain();
    check("zero", 32'(out), 32'h00000);

    // Backpressure: result held while consumer stalls.
    out_ready = 1'b0;
    send(16'h1234, 16'hFEDC);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 32'(out_valid), 1);
    held = out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_out", 32'(out), 32'(held));
      check("bp_hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_out_kept", 32'(out), 32'(held));

    // Operand and in_valid changes during RUN are ignored.
    send(16'hFFF0, 16'h0010);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a = N'($urandom);
      b = N'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    check("ignore_result", 32'(out), 32'h1FFE0);
    repeat (3) @(negedge clk);
    check("ignore_no_second_busy", 32'(busy), 0);
    check("ignore_no_second_sb", 32'(sb.size()), 0);

    // Reset while cnt=7 aborts the operation.
    send(16'h4321, 16'h0101);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    sb.delete();
    send(16'hFFFF, 16'h0001);
    drain();
    check("after_abort", 32'(out), 32'h1FFFE);

    // Random operands with random producer gaps and consumer stalls.
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send(N'($urandom), N'($urandom));
        end
        prod_done = 1'b1;
      end
      begin
        int k = 0;
        while (!(prod_done && sb.size() == 0 && !busy) && k < 90000) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
          k++;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
